// File: rtl/fsm_transition_tracer_if.sv
// Trace read port of fsm_transition_tracer: FWFT head record with a valid/ready handshake.
interface fsm_transition_tracer_if #(
  parameter int unsigned STATE_W = 4,
  parameter int unsigned TS_W    = 16
);
  logic               trace_valid;
  logic               trace_ready;
  logic [STATE_W-1:0] trace_from;
  logic [STATE_W-1:0] trace_to;
  logic [TS_W-1:0]    trace_dwell;

  modport master (
    output trace_valid,
    output trace_from,
    output trace_to,
    output trace_dwell,
    input  trace_ready
  );

  modport slave (
    input  trace_valid,
    input  trace_from,
    input  trace_to,
    input  trace_dwell,
    output trace_ready
  );
endinterface

// File: rtl/fsm_transition_tracer.sv
// Samples an FSM state register, queues {from, to, dwell} per transition in an FWFT FIFO and
// keeps sticky illegal/overflow status. Define FSM_TRACER_LOG_EN for simulation-only logging.
module fsm_transition_tracer #(
  parameter int unsigned STATE_W    = 4,
  parameter int unsigned NUM_STATES = 7,
  parameter int unsigned TS_W       = 16,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [STATE_W-1:0]      state_i,
  input  logic                    clear_i,
  fsm_transition_tracer_if.master trace,
  output logic                    illegal,
  output logic [STATE_W-1:0]      illegal_state,
  output logic                    overflow,
  output logic [7:0]              drop_cnt
);

  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FullCnt = (AW + 1)'(DEPTH);

  logic [STATE_W-1:0] prev_q, prev_d;
  logic [TS_W-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]        count_q, count_d;
  logic               illegal_q, illegal_d;
  logic [STATE_W-1:0] ill_state_q, ill_state_d;
  logic               overflow_q, overflow_d;
  logic [7:0]         drop_q, drop_d;

  logic [STATE_W-1:0] mem_from  [DEPTH];
  logic [STATE_W-1:0] mem_to    [DEPTH];
  logic [TS_W-1:0]    mem_dwell [DEPTH];

  logic transition, ill_sample, empty, full, pop, push_ok, drop;

  assign transition = (state_i != prev_q);
  assign ill_sample = (32'(state_i) >= NUM_STATES);
  assign empty      = (count_q == '0);
  assign full       = (count_q == FullCnt);
  assign pop        = !empty && trace.trace_ready;
  // A full FIFO still accepts a record when the head leaves in the same cycle.
  assign push_ok    = transition && (!full || pop);
  assign drop       = transition && full && !pop;

  always_comb begin
    prev_d      = prev_q;
    cnt_d       = cnt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    illegal_d   = illegal_q;
    ill_state_d = ill_state_q;
    overflow_d  = overflow_q;
    drop_d      = drop_q;

    if (transition) begin
      prev_d = state_i;
      cnt_d  = TS_W'(1);
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + TS_W'(1);
    end

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase

    // Clear first so an event sampled in the same cycle wins.
    if (clear_i) begin
      illegal_d   = 1'b0;
      ill_state_d = '0;
      overflow_d  = 1'b0;
      drop_d      = '0;
    end

    if (ill_sample) begin
      illegal_d = 1'b1;
      if (!illegal_q || clear_i) begin
        ill_state_d = state_i;
      end
    end

    if (drop) begin
      overflow_d = 1'b1;
      if (drop_d != 8'hff) begin
        drop_d = drop_d + 8'd1;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      prev_q      <= '0;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      illegal_q   <= 1'b0;
      ill_state_q <= '0;
      overflow_q  <= 1'b0;
      drop_q      <= '0;
    end else begin
      prev_q      <= prev_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      illegal_q   <= illegal_d;
      ill_state_q <= ill_state_d;
      overflow_q  <= overflow_d;
      drop_q      <= drop_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (push_ok) begin
      mem_from[wr_ptr_q]  <= prev_q;
      mem_to[wr_ptr_q]    <= state_i;
      mem_dwell[wr_ptr_q] <= cnt_q;
    end
  end

  assign trace.trace_valid = !empty;
  assign trace.trace_from  = empty ? '0 : mem_from[rd_ptr_q];
  assign trace.trace_to    = empty ? '0 : mem_to[rd_ptr_q];
  assign trace.trace_dwell = empty ? '0 : mem_dwell[rd_ptr_q];

  assign illegal       = illegal_q;
  assign illegal_state = ill_state_q;
  assign overflow      = overflow_q;
  assign drop_cnt      = drop_q;

`ifdef FSM_TRACER_LOG_EN
  svlogger logger = new("FsmTracer");

  always @(posedge aclk) begin
    if (aresetn) begin
      if (push_ok) begin
        logger.info($sformatf("record from=%0d to=%0d dwell=%0d", prev_q, state_i, cnt_q));
      end
      if (ill_sample && (!illegal_q || clear_i)) begin
        logger.error($sformatf("illegal state %0d sampled", state_i));
      end
      if (drop) begin
        logger.warning($sformatf("record dropped from=%0d to=%0d", prev_q, state_i));
      end
    end
  end
`endif

endmodule

// File: tb/tb_fsm_transition_tracer.sv
// Scoreboarded bench for fsm_transition_tracer plus a TS_W=4 instance for dwell saturation.
module tb_fsm_transition_tracer;

  localparam int unsigned DEPTH = 8;

  typedef struct {
    logic [3:0]  fr;
    logic [3:0]  to;
    logic [15:0] dw;
  } rec_t;

  logic       aclk;
  logic       aresetn;
  logic [3:0] state_i;
  logic       clear_i;
  logic       illegal;
  logic [3:0] illegal_state;
  logic       overflow;
  logic [7:0] drop_cnt;

  logic [3:0] state4;
  logic       illegal4;
  logic [3:0] illegal_state4;
  logic       overflow4;
  logic [7:0] drop_cnt4;

  fsm_transition_tracer_if #(.STATE_W(4), .TS_W(16)) tif ();
  fsm_transition_tracer_if #(.STATE_W(4), .TS_W(4))  tif4 ();

  fsm_transition_tracer #(
    .STATE_W(4), .NUM_STATES(7), .TS_W(16), .DEPTH(DEPTH)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .state_i       (state_i),
    .clear_i       (clear_i),
    .trace         (tif.master),
    .illegal       (illegal),
    .illegal_state (illegal_state),
    .overflow      (overflow),
    .drop_cnt      (drop_cnt)
  );

  fsm_transition_tracer #(
    .STATE_W(4), .NUM_STATES(7), .TS_W(4), .DEPTH(DEPTH)
  ) dut4 (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .state_i       (state4),
    .clear_i       (1'b0),
    .trace         (tif4.master),
    .illegal       (illegal4),
    .illegal_state (illegal_state4),
    .overflow      (overflow4),
    .drop_cnt      (drop_cnt4)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int   n_checks = 0;
  int   n_errors = 0;
  rec_t exp_q[$];
  logic [3:0]  m_prev;
  logic [15:0] m_cnt;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_prev = '0;
    m_cnt  = '0;
  endtask

  // One clock edge: score the head consumed at this edge, predict the push, then sample at +1.
  task automatic step();
    rec_t r;
    bit   popped;
    bit   full;
    popped = 1'b0;
    full   = (exp_q.size() == DEPTH);
    if (tif.trace_valid && tif.trace_ready) begin
      popped = 1'b1;
      if (exp_q.size() == 0) begin
        check_eq("spurious_rec", 32'd1, 32'd0);
      end else begin
        r = exp_q.pop_front();
        check_eq("rec_from", 32'(tif.trace_from), 32'(r.fr));
        check_eq("rec_to", 32'(tif.trace_to), 32'(r.to));
        check_eq("rec_dwell", 32'(tif.trace_dwell), 32'(r.dw));
      end
    end
    if (state_i != m_prev) begin
      if (!full || popped) exp_q.push_back('{fr: m_prev, to: state_i, dw: m_cnt});
      m_prev = state_i;
      m_cnt  = 16'd1;
    end else if (m_cnt != 16'hffff) begin
      m_cnt = m_cnt + 16'd1;
    end
    @(posedge aclk);
    #1;
    check_eq("valid", 32'(tif.trace_valid), 32'(exp_q.size() != 0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    aresetn         = 1'b0;
    state_i         = 4'd0;
    clear_i         = 1'b0;
    tif.trace_ready = 1'b0;
    state4          = 4'd0;
    tif4.trace_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge aclk);
    #1;
    check_eq("rst_valid", 32'(tif.trace_valid), 32'd0);
    check_eq("rst_from", 32'(tif.trace_from), 32'd0);
    check_eq("rst_dwell", 32'(tif.trace_dwell), 32'd0);
    check_eq("rst_illegal", 32'(illegal), 32'd0);
    check_eq("rst_overflow", 32'(overflow), 32'd0);
    check_eq("rst_drop", 32'(drop_cnt), 32'd0);
    aresetn = 1'b1;

    // Hold 0 for three edges, then move to 1.
    repeat (3) step();
    state_i = 4'd1;
    step();
    check_eq("t1_from", 32'(tif.trace_from), 32'd0);
    check_eq("t1_to", 32'(tif.trace_to), 32'd1);
    check_eq("t1_dwell", 32'(tif.trace_dwell), 32'd3);

    // Single-cycle walk 1->2->3->4->0 with the consumer always ready.
    tif.trace_ready = 1'b1;
    for (int s = 2; s <= 5; s++) begin
      state_i = 4'(s % 5);
      step();
    end
    repeat (2) step();
    check_eq("t2_illegal", 32'(illegal), 32'd0);
    check_eq("t2_overflow", 32'(overflow), 32'd0);

    // Ten transitions into an 8-deep FIFO with no consumer.
    tif.trace_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      state_i = (i % 2 == 0) ? 4'd1 : 4'd0;
      step();
      check_eq("t3_overflow", 32'(overflow), 32'(i >= 8));
      check_eq("t3_drop", 32'(drop_cnt), (i >= 8) ? 32'(i - 7) : 32'd0);
    end
    tif.trace_ready = 1'b1;
    state_i = 4'd1;
    step();
    check_eq("t3_full_pushpop_drop", 32'(drop_cnt), 32'd2);
    repeat (10) step();

    // Illegal encodings, clear, and clear colliding with an illegal sample.
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    check_eq("t4_clr_overflow", 32'(overflow), 32'd0);
    check_eq("t4_clr_drop", 32'(drop_cnt), 32'd0);
    state_i = 4'd9;
    step();
    check_eq("t4_illegal", 32'(illegal), 32'd1);
    state_i = 4'd12;
    step();
    state_i = 4'd3;
    step();
    check_eq("t4_illegal_hold", 32'(illegal), 32'd1);
    check_eq("t4_ill_state", 32'(illegal_state), 32'd9);
    clear_i = 1'b1;
    step();
    check_eq("t4_clr_illegal", 32'(illegal), 32'd0);
    check_eq("t4_clr_ill_state", 32'(illegal_state), 32'd0);
    state_i = 4'd12;
    step();
    clear_i = 1'b0;
    check_eq("t4_clr_win_illegal", 32'(illegal), 32'd1);
    check_eq("t4_clr_win_state", 32'(illegal_state), 32'd12);
    state_i = 4'd0;
    step();
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    repeat (2) step();

    // Reset with three records queued and a sticky flag set.
    tif.trace_ready = 1'b0;
    state_i = 4'd9;
    step();
    state_i = 4'd2;
    step();
    state_i = 4'd1;
    step();
    check_eq("t5_pre_illegal", 32'(illegal), 32'd1);
    aresetn = 1'b0;
    state_i = 4'd0;
    #1;
    check_eq("t5_rst_valid", 32'(tif.trace_valid), 32'd0);
    check_eq("t5_rst_illegal", 32'(illegal), 32'd0);
    check_eq("t5_rst_ill_state", 32'(illegal_state), 32'd0);
    check_eq("t5_rst_overflow", 32'(overflow), 32'd0);
    check_eq("t5_rst_drop", 32'(drop_cnt), 32'd0);
    model_reset();
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    tif.trace_ready = 1'b1;
    step();
    state_i = 4'd2;
    step();
    check_eq("t5_from", 32'(tif.trace_from), 32'd0);
    check_eq("t5_to", 32'(tif.trace_to), 32'd2);
    check_eq("t5_dwell", 32'(tif.trace_dwell), 32'd1);

    // TS_W=4 instance: long hold saturates at 15, a 14-cycle hold does not.
    repeat (20) step();
    state4 = 4'd3;
    step();
    check_eq("t6_valid", 32'(tif4.trace_valid), 32'd1);
    check_eq("t6_from", 32'(tif4.trace_from), 32'd0);
    check_eq("t6_to", 32'(tif4.trace_to), 32'd3);
    check_eq("t6_sat_dwell", 32'(tif4.trace_dwell), 32'd15);
    repeat (13) step();
    state4 = 4'd0;
    step();
    check_eq("t6_from2", 32'(tif4.trace_from), 32'd3);
    check_eq("t6_dwell14", 32'(tif4.trace_dwell), 32'd14);
    repeat (2) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
